spi_register_port: RTL

SPI mode-0 slave that turns serial frames from the host MCU into single-cycle register writes for the synth configuration bus (RegisterNumber / RegisterValue / RegisterWriteEnable).
- Sits between the board SPI pins and the top-level synth register inputs.
- Oversamples SCK/CS_n/MOSI in the system clock domain, frames 32-bit writes and echoes the last accepted write on MISO for host-side confirmation.

---
 rtl/spi_register_port.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/spi_register_port.sv
// SPI mode-0 slave: frames 32-bit host writes into one-cycle register-bus strobes and echoes the last write on MISO.
// Optional SPI_AUTO_INCREMENT_EN: words after the first write auto-increment the register number (burst mode).
module spi_register_port #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 32
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_SCK,
    input  logic        i_CS_n,
    input  logic        i_MOSI,
    output logic        o_MISO,
    output logic [15:0] o_RegisterNumber,
    output logic [15:0] o_RegisterValue,
    output logic        o_RegisterWriteEnable,
    output logic        o_FrameError
);

    localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_ADDR      = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_WRITE     = 3'd4;
    localparam logic [2:0] ST_TAIL      = 3'd5;  // DONE, or BURST when auto-increment is built in

    localparam logic [5:0] FULL_COUNT = 6'(FRAME_BITS);
    localparam logic [5:0] HALF_COUNT = 6'(FRAME_BITS / 2);

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_last_q, cs_last_q;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;

    logic [2:0]  state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] shift_q, shift_d;
    logic [15:0] echo_q, echo_d;
    logic [15:0] num_q, num_d;
    logic [15:0] val_q, val_d;
    logic        we_q, we_d;
    logic        err_q, err_d;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Edges are taken between the last synchroniser stage and one extra history flop.
    assign sck_rise = sck_s & ~sck_last_q;
    assign sck_fall = ~sck_s & sck_last_q;
    assign cs_rise  = cs_s & ~cs_last_q;
    assign cs_fall  = ~cs_s & cs_last_q;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_last_q  <= 1'b0;
            cs_last_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_SCK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_CS_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_MOSI};
            sck_last_q  <= sck_s;
            cs_last_q   <= cs_s;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        echo_d  = echo_q;
        num_d   = num_q;
        val_d   = val_q;
        we_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_WAIT_IDLE: begin
                if (cs_s) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_ADDR;
                    count_d = 6'd0;
                    echo_d  = num_q;
                end
            end
            ST_ADDR, ST_DATA: begin
                if (sck_rise) begin
                    shift_d = {shift_q[30:0], mosi_s};
                    count_d = count_q + 6'd1;
                end
                // The value echo is loaded on bit 16; the fall right after it must not shift it.
                if (sck_fall && count_q != HALF_COUNT)
                    echo_d = {echo_q[14:0], 1'b0};
                if (sck_rise && count_d == FULL_COUNT) begin
                    state_d = ST_WRITE;
                    num_d   = shift_d[31:16];
                    val_d   = shift_d[15:0];
                    we_d    = 1'b1;
                end else if (cs_rise) begin
                    state_d = ST_IDLE;
                    err_d   = (count_d != 6'd0);
                end else if (sck_rise && count_d == HALF_COUNT && state_q == ST_ADDR) begin
                    state_d = ST_DATA;
                    echo_d  = val_q;
                end
            end
            ST_WRITE: begin
                count_d = 6'd0;
                state_d = cs_s ? ST_IDLE : ST_TAIL;
            end
            ST_TAIL: begin
`ifdef SPI_AUTO_INCREMENT_EN
                if (sck_rise) begin
                    shift_d = {shift_q[30:0], mosi_s};
                    count_d = count_q + 6'd1;
                end
                if (sck_rise && count_d == HALF_COUNT) begin
                    state_d = ST_WRITE;
                    num_d   = num_q + 16'd1;
                    val_d   = shift_d[15:0];
                    we_d    = 1'b1;
                end else if (cs_rise) begin
                    state_d = ST_IDLE;
                    err_d   = (count_d != 6'd0);
                end
`else
                if (cs_rise) state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= ST_WAIT_IDLE;
            count_q <= '0;
            shift_q <= '0;
            echo_q  <= '0;
            num_q   <= '0;
            val_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            echo_q  <= echo_d;
            num_q   <= num_d;
            val_q   <= val_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign o_MISO                = ((state_q == ST_ADDR) || (state_q == ST_DATA)) & echo_q[15];
    assign o_RegisterNumber      = num_q;
    assign o_RegisterValue       = val_q;
    assign o_RegisterWriteEnable = we_q;
    assign o_FrameError          = err_q;

endmodule
